alu_sweep_checker: RTL and testbench

- Hardware self-check engine for the 4-bit ALU; this is the response/driver end of the ALU operand interface.
- Sweeps every {sel, A, B} combination (1024 vectors), drives them into the ALU, waits a programmable settle time, and samples result/carry_out.
- Compares each sample against an internal golden model and counts mismatches.
- Used for on-chip BIST of the ALU and as a synthesizable checker in system sims.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_ref_model.sv | 37 +++
 rtl/alu_sweep_checker.sv | 121 ++++++++++++
 tb/tb_alu_sweep_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU select encodings and checker FSM states
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int SEL_W = 2;
  localparam int IDX_W = 10;
  localparam int ERR_W = 11;

  localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [SEL_W-1:0] ALU_AND = 2'b10;
  localparam logic [SEL_W-1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } chk_state_t;

endpackage

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational golden model of the 4-bit ALU
//
// Ports:
//   a, b    operands
//   sel     operation select (ADD, SUB, AND, OR)
//   result  expected 4-bit result
//   carry   expected carry-out (ADD carry, SUB borrow, 0 for logic ops)
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [ALU_W-1:0] result,
  output logic             carry
);

  logic [ALU_W:0] sum;
  logic [ALU_W:0] diff;

  // The extra MSB of the 5-bit difference is exactly the borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (sel)
      ALU_ADD: {carry, result} = sum;
      ALU_SUB: {carry, result} = diff;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sweep_checker.sv
// rtl/alu_sweep_checker.sv - exhaustive ALU sweep engine with mismatch counting
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 single-cycle pulse to begin a sweep (ignored while busy)
//   alu_a/alu_b/alu_sel   vector driven into the ALU under test
//   alu_result/alu_carry  ALU response, sampled SETTLE_CYCLES after each vector
//   busy, done, pass      sweep status; done/pass held until next start or rst
//   err_count             number of mismatching vectors
//   first_fail            {sel,A,B} of the first mismatch
//
// Build option: ALU_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch,
// holding the failing vector on the ALU outputs.
module alu_sweep_checker
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [ALU_W-1:0] alu_result,
  input  logic             alu_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST    = '1;

  chk_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       settle_cnt;
  logic [ALU_W-1:0] exp_result;
  logic             exp_carry;
  logic             mismatch;
  logic             launch;

  // The vector register is the ALU drive itself, so the outputs are registered.
  assign alu_sel = idx[IDX_W-1 -: SEL_W];
  assign alu_a   = idx[2*ALU_W-1 -: ALU_W];
  assign alu_b   = idx[ALU_W-1:0];

  alu_ref_model u_ref (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (alu_sel),
    .result (exp_result),
    .carry  (exp_carry)
  );

  assign mismatch = ({alu_carry, alu_result} != {exp_carry, exp_result});
  assign launch   = start && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else if (launch) begin
      state      <= ST_SETTLE;
      idx        <= '0;
      settle_cnt <= SETTLE_LOAD;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_SETTLE: begin
          // Counter starts at SETTLE_CYCLES, so the vector is held that many cycles.
          if (settle_cnt <= 4'd1) state <= ST_CHECK;
          else                    settle_cnt <= settle_cnt - 4'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count == '0) first_fail <= idx;
            err_count <= err_count + ERR_W'(1);
          end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
          if (mismatch || idx == IDX_LAST) begin
            state <= ST_DONE;
          end else begin
            idx        <= idx + IDX_W'(1);
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end
`else
          if (idx == IDX_LAST) begin
            state <= ST_DONE;
          end else begin
            idx        <= idx + IDX_W'(1);
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end
`endif
        end
        ST_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_count == '0);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_checker.sv
// tb/tb_alu_sweep_checker.sv - self-checking bench for alu_sweep_checker
module tb_alu_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;

  logic [3:0]  a1, b1, r1;
  logic [1:0]  s1;
  logic        c1, busy1, done1, pass1;
  logic [10:0] err1;
  logic [9:0]  ff1;

  logic [3:0]  a2, b2, r2;
  logic [1:0]  s2;
  logic        c2, busy2, done2, pass2;
  logic [10:0] err2;
  logic [9:0]  ff2;

  int errors = 0;
  int checks = 0;

  // 0: correct ALU, 1: carry stuck-at-0, 2: result bit0 flipped where fault_mask set
  int            fault_mode;
  logic [1023:0] fault_mask;

  alu_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .alu_a(a1), .alu_b(b1), .alu_sel(s1),
    .alu_result(r1), .alu_carry(c1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  alu_sweep_checker #(.SETTLE_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .alu_a(a2), .alu_b(b2), .alu_sel(s2),
    .alu_result(r2), .alu_carry(c2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail(ff2)
  );

  // Expected {carry,result} straight from the ALU contract, using integer arithmetic.
  function automatic logic [4:0] golden(input logic [9:0] v);
    int a, b, r, c;
    a = int'(v[7:4]);
    b = int'(v[3:0]);
    c = 0;
    case (v[9:8])
      2'd0: begin r = a + b; c = (r >= 16) ? 1 : 0; r = r % 16; end
      2'd1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {c[0], r[3:0]};
  endfunction

  function automatic logic [4:0] faulty(input logic [9:0] v);
    logic [4:0] g;
    g = golden(v);
    if (fault_mode == 1) g[4] = 1'b0;
    else if (fault_mode == 2 && fault_mask[v]) g[0] = ~g[0];
    return g;
  endfunction

  assign {c1, r1} = faulty({s1, a1, b1});

  // Slow ALU wrapper: output registered twice.
  logic [4:0] p1, p2;
  always_ff @(posedge clk) begin
    p1 <= golden({s2, a2, b2});
    p2 <= p1;
  end
  assign {c2, r2} = p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard for a whole sweep: count and locate vectors the faulty ALU gets wrong.
  task automatic expect_sweep(output int n, output int first);
    n = 0;
    first = 0;
    for (int i = 0; i < 1024; i++) begin
      if (faulty(10'(i)) != golden(10'(i))) begin
        if (n == 0) first = i;
        n++;
      end
    end
  endtask

  // Pulse start on dut1 and count cycles from the start edge until done is seen.
  task automatic run_sweep(input bit extra, output int cyc, output logic busy_after,
                           output logic done_after);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    busy_after = busy1;
    done_after = done1;
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done1) break;
      start = extra && (cyc == 9 || cyc == 999);
    end
    start = 1'b0;
  endtask

  task automatic check_full(input string tag, input int n, input int first);
    int cyc;
    logic ba, da;
    run_sweep(1'b0, cyc, ba, da);
    check({tag, "_busy_after_start"}, 32'(ba), 1);
    check({tag, "_done_cleared"}, 32'(da), 0);
`ifdef ALU_CHK_STOP_ON_FAIL_EN
    check({tag, "_cycles"}, cyc, (n != 0) ? (first + 1) * 2 + 1 : 2049);
    check({tag, "_err"}, 32'(err1), (n != 0) ? 1 : 0);
    check({tag, "_vec_held"}, 32'({s1, a1, b1}), (n != 0) ? first : 1023);
`else
    check({tag, "_cycles"}, cyc, 2049);
    check({tag, "_err"}, 32'(err1), n);
    check({tag, "_vec_held"}, 32'({s1, a1, b1}), 1023);
`endif
    check({tag, "_first_fail"}, 32'(ff1), first);
    check({tag, "_pass"}, 32'(pass1), (n == 0) ? 1 : 0);
    check({tag, "_busy_end"}, 32'(busy1), 0);
  endtask

  initial begin
    int cyc, n, first;
    logic ba, da;

    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    fault_mode = 0; fault_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_pass", 32'(pass1), 0);
    check("rst_err", 32'(err1), 0);
    check("rst_ff", 32'(ff1), 0);
    check("rst_vec", 32'({s1, a1, b1}), 0);
    check("rst2_done", 32'(done2), 0);
    rst = 1'b0;

    // Clean sweep with spurious start pulses mid-sweep.
    run_sweep(1'b1, cyc, ba, da);
    check("clean_busy", 32'(ba), 1);
    check("clean_cycles", cyc, 2049);
    check("clean_pass", 32'(pass1), 1);
    check("clean_err", 32'(err1), 0);
    check("clean_done", 32'(done1), 1);
    check("clean_busy_end", 32'(busy1), 0);

    // Carry stuck-at-0, restarted from DONE.
    fault_mode = 1;
    expect_sweep(n, first);
    check_full("stuck_carry", n, first);

    // Random sparse result-bit faults.
    fault_mode = 2;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1024; i++) fault_mask[i] = ($urandom_range(0, 40) == 0);
      expect_sweep(n, first);
      check_full("rand_fault", n, first);
    end

    // Reset in the middle of a sweep, then a full clean sweep.
    fault_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (499) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_busy", 32'(busy1), 0);
    check("midrst_done", 32'(done1), 0);
    check("midrst_err", 32'(err1), 0);
    check("midrst_ff", 32'(ff1), 0);
    check("midrst_vec", 32'({s1, a1, b1}), 0);
    run_sweep(1'b0, cyc, ba, da);
    check("after_rst_cycles", cyc, 2049);
    check("after_rst_pass", 32'(pass1), 1);

    // Slow ALU behind two registers with SETTLE_CYCLES=3.
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 0;
    while (cyc < 10000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done2) break;
    end
    check("slow_cycles", cyc, 4097);
    check("slow_pass", 32'(pass2), 1);
    check("slow_err", 32'(err2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
